// File: rtl/warp_mbus_arbiter.sv
// Three-master Wishbone-style arbiter in front of the SDRAM controller: M0 (video) has fixed
// priority, M1/M2 alternate round-robin, and a watchdog aborts transfers the slave never acks.
module warp_mbus_arbiter #(
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [95:0] m_adr_i,
    input  logic [2:0]  m_stb_i,
    input  logic [2:0]  m_we_i,
    input  logic [11:0] m_sel_i,
    input  logic [95:0] m_dat_i,
    output logic [2:0]  m_ack_o,
    output logic [2:0]  m_err_o,
    output logic [31:0] m_dat_o,
    output logic [31:0] s_adr_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [2:0]  grant_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_r, state_s;
    logic [2:0]      grant_r, grant_s;
    logic            rr_last_r, rr_last_s;   // 1'b0 = M1 last won, 1'b1 = M2 last won
    logic [TO_W-1:0] cnt_r, cnt_s;
    logic [2:0]      err_r, err_s;

    logic [31:0]     g_adr_s;
    logic [31:0]     g_dat_s;
    logic [3:0]      g_sel_s;
    logic            g_we_s;
    logic            g_stb_s;
    logic            busy_s;

    // Select the granted master's request fields.
    always_comb begin
        g_adr_s = 32'h0000_0000;
        g_dat_s = 32'h0000_0000;
        g_sel_s = 4'b0000;
        g_we_s  = 1'b0;
        g_stb_s = 1'b0;
        case (grant_r)
            3'b001: begin
                g_adr_s = m_adr_i[31:0];
                g_dat_s = m_dat_i[31:0];
                g_sel_s = m_sel_i[3:0];
                g_we_s  = m_we_i[0];
                g_stb_s = m_stb_i[0];
            end
            3'b010: begin
                g_adr_s = m_adr_i[63:32];
                g_dat_s = m_dat_i[63:32];
                g_sel_s = m_sel_i[7:4];
                g_we_s  = m_we_i[1];
                g_stb_s = m_stb_i[1];
            end
            3'b100: begin
                g_adr_s = m_adr_i[95:64];
                g_dat_s = m_dat_i[95:64];
                g_sel_s = m_sel_i[11:8];
                g_we_s  = m_we_i[2];
                g_stb_s = m_stb_i[2];
            end
            default: begin
                g_stb_s = 1'b0;
            end
        endcase
    end

    assign busy_s  = (state_r == BUSY);
    assign s_adr_o = g_adr_s;
    assign s_dat_o = g_dat_s;
    assign s_sel_o = g_sel_s;
    assign s_we_o  = g_we_s;
    assign s_stb_o = busy_s & g_stb_s;
    assign m_dat_o = s_dat_i;
    assign m_err_o = err_r;
    assign grant_o = busy_s ? grant_r : 3'b000;
    // Ack is gated by the master's own strobe so a dropped request never sees an ack.
    assign m_ack_o = (busy_s && s_ack_i && g_stb_s) ? grant_r : 3'b000;

    // Next-state, arbitration and watchdog logic.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        rr_last_s = rr_last_r;
        cnt_s     = cnt_r;
        err_s     = 3'b000;
        case (state_r)
            IDLE: begin
                cnt_s = {TO_W{1'b0}};
                if (|m_stb_i) begin
                    state_s = BUSY;
                    if (m_stb_i[0]) begin
                        grant_s = 3'b001;
                    end else if (m_stb_i[1] && (!m_stb_i[2] || rr_last_r)) begin
                        grant_s   = 3'b010;
                        rr_last_s = 1'b0;
                    end else begin
                        grant_s   = 3'b100;
                        rr_last_s = 1'b1;
                    end
                end else begin
                    grant_s = 3'b000;
                end
            end
            BUSY: begin
                if (!g_stb_s || s_ack_i) begin
                    state_s = IDLE;
                    cnt_s   = {TO_W{1'b0}};
                end else if (cnt_r == TO_LAST) begin
                    state_s = IDLE;
                    cnt_s   = {TO_W{1'b0}};
                    err_s   = grant_r;
                end else begin
                    cnt_s = cnt_r + TO_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {TO_W{1'b0}};
            end
        endcase
    end

    // State, grant, round-robin pointer, watchdog and error registers.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_r   <= IDLE;
            grant_r   <= 3'b000;
            rr_last_r <= 1'b1;
            cnt_r     <= {TO_W{1'b0}};
            err_r     <= 3'b000;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            rr_last_r <= rr_last_s;
            cnt_r     <= cnt_s;
            err_r     <= err_s;
        end
    end

endmodule

// File: doc/warp_mbus_arbiter.md
Name: warp_mbus_arbiter

Overview:
- Shares one 32-bit Wishbone-style memory master port among three requesters: video scanout (M0), warp core master (M1) and CPU data master (M2).
- Sits between those masters and the SDRAM controller.
- Fixed priority for M0; fair round-robin between M1 and M2.
- A bus-timeout watchdog releases the bus if a slave never acknowledges.

Parameters:
- TIMEOUT, 1023, cycles in BUSY without s_ack_i before the transfer is aborted with error (range 1..1023).
- TO_W, 10, width of the timeout counter.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_n_i  in  1  synchronous reset, active low
- m_adr_i  in  96  addresses, M0 in [31:0], M1 in [63:32], M2 in [95:64]
- m_stb_i  in  3  per-master strobe/request, held until ack or err
- m_we_i  in  3  per-master write enable
- m_sel_i  in  12  byte selects, 4 bits per master
- m_dat_i  in  96  write data, 32 bits per master
- m_ack_o  out  3  per-master acknowledge
- m_err_o  out  3  per-master timeout error
- m_dat_o  out  32  read data, s_dat_i broadcast to all masters
- s_adr_o  out  32  slave address
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable
- s_sel_o  out  4  slave byte selects
- s_dat_o  out  32  slave write data
- s_ack_i  in  1  slave acknowledge, one-cycle pulse
- s_dat_i  in  32  slave read data
- grant_o  out  3  one-hot current grant, for debug and perf counters

Behaviour:
- Reset (wb_rst_n_i low at a clock edge) forces:
  - state IDLE, grant 3'b000, timeout counter 0;
  - rr_last = M2, so M1 wins the first M1/M2 tie;
  - s_stb_o=0, m_ack_o=0, m_err_o=0.
- Reset asserted mid-transfer aborts it silently: no ack, no err.
- State machine IDLE / BUSY:
  - IDLE: outputs s_stb_o=0. If any m_stb_i is set, register the grant and enter BUSY next cycle. This gives exactly one cycle of arbitration latency.
  - Grant selection: M0 if requesting. Otherwise, if only one of M1/M2 requests, grant it. If both request, grant the one not equal to rr_last. rr_last updates to the granted M1/M2 index; it is unchanged by M0 grants.
  - BUSY: s_adr_o, s_we_o, s_sel_o, s_dat_o and s_stb_o are a combinational mux from the granted master's inputs. The timeout counter increments each cycle.
  - BUSY with s_ack_i=1: m_ack_o[g] = 1 in the same cycle (combinational). Next state IDLE, counter cleared.
  - BUSY with the counter reaching TIMEOUT-1 and no ack: m_err_o[g] pulses for one cycle (registered) and s_stb_o drops. Next state IDLE.
  - BUSY with the granted m_stb_i dropping before ack (protocol violation): abort, go IDLE, no ack, no err.
- No preemption: M0 arriving while M1 or M2 is BUSY waits for completion.
- Back-to-back requests: the next grant is decided in the IDLE cycle after an ack. The bus idles at least one cycle between transfers.
- s_ack_i while IDLE is ignored and produces no m_ack_o.
- m_ack_o and m_err_o are never set for a non-granted master. They are never both set in the same cycle.
- When IDLE, the s_adr_o, s_we_o, s_sel_o and s_dat_o values are don't-care. The bench checks them only while s_stb_o=1.
- grant_o equals the registered grant in BUSY and 0 in IDLE.

Test Plan:
- Single M1 read: adr 0x00000040; slave acks 3 cycles after s_stb_o rises with s_dat_i=0xDEADBEEF. Expect s_stb_o rising 1 cycle after m_stb_i, m_ack_o=3'b010 for exactly one cycle, m_dat_o=0xDEADBEEF.
- M1 and M2 requesting continuously, slave acking every second cycle. Expect grants M1, M2, M1, M2…, with exactly one IDLE cycle between grants.
- M0 raises stb while M1 is BUSY. Expect M1 to complete first, then M0 granted before a pending M2. M0 held continuously starves M1 and M2: this is accepted behaviour.
- M2 write 0x12345678, sel 4'b0011, to 0x40000100. Expect s_we_o=1, s_sel_o=4'b0011, s_dat_o=0x12345678 throughout BUSY.
- Timeout with TIMEOUT=8 and no ack to an M1 request. Expect m_err_o[1] high for one cycle, 8 cycles after BUSY entry. Expect s_stb_o low the same cycle and no m_ack_o.
- wb_rst_n_i low for 1 cycle while M2 is BUSY. Expect all outputs 0 and grant_o=0. After release, simultaneous M1/M2 requests grant M1 first. A stray s_ack_i in IDLE produces no ack.
